serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full-adder cell across a WIDTH-bit addition, LSB first.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Sits between a requester, such as a lab top-level or a testbench driver, and the existing full-adder leaf cell.
- Trades WIDTH cycles of latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, derived as clog2(WIDTH+1), bit-counter width; not user-overridable.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse, high only in DONE.
- sum  out  WIDTH  registered result; holds until next completion.
- cout  out  1  registered carry-out; holds until next completion.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Encoding constants live in the package.
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0; sum=0; cout=0.
  - Operand regs, carry FF and counter cleared.
- IDLE:
  - start=1 at an edge: latch a, b into shift regs; carry FF=cin; cnt=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, per edge:
  - Full-adder cell inputs are bit0 of the A reg, bit0 of the B reg and the carry FF.
  - Cell sum bit shifts into the MSB of the result reg (right shift).
  - A/B regs shift right; carry FF takes the cell carry-out; cnt++.
  - When cnt==WIDTH-1 at the edge, go to DONE.
  - On that same edge, sum and cout output regs load the final result reg contents (including the last bit) and the carry.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Accepted start edge E0; done high during the cycle after edge E0+WIDTH.
  - New start accepted no earlier than edge E0+WIDTH+2.
- start during SHIFT or DONE is ignored; no queueing; operands are not re-latched.
- a, b and cin may change freely after the accept edge without affecting the result.
- sum/cout are unchanged during SHIFT and keep the previous result until the DONE transition.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- Reset mid-operation aborts immediately:
  - Outputs go to reset values.
  - No done pulse is produced for the aborted operation.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum/cout.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow).
  - Needs one extra FF holding the MSB carry-in; reset 0.
- Undefined: port absent; no extra logic; all other behaviour identical.

Decomposition:
- Package serial_add_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One sub-module: reuse the existing combinational full-adder cell fa, port order (Cin, A, B, Cout, Sum).
  - Instantiated exactly once; no inline adder logic.
- Counter, shift regs and FSM stay in serial_add_ctrl.

Test Plan (WIDTH=8):
1. Basic add: a=0x3C, b=0x5A, cin=0, start pulse at E0 -> busy=1 from E0; done pulse after E0+8; sum=0x96, cout=0.
2. Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. Busy protection:
   - Start a=0x10, b=0x20, then start=1 with a=0xAA, b=0x55 held through SHIFT.
   - Required: sum=0x30, single done pulse.
   - Next accept occurs only after IDLE is re-entered.
4. Reset mid-op:
   - Start a=0x81, b=0x81; assert rst_n=0 after E0+3 between edges.
   - Required: busy, done, sum, cout = 0 immediately (async).
   - No done pulse after release.
   - Fresh start a=0x01, b=0x02 -> sum=0x03.
5. Back-to-back:
   - Start held high continuously with a=0x0F, b=0x01.
   - Required: done pulses every 10 edges; sum=0x10 each time.
6. With SERIAL_ADD_OVF_EN:
   - a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
   - a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encoding and default width.
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Combinational 1-bit full-adder leaf cell shared across every bit of a serial add.
module fa (
    input  logic Cin,
    input  logic A,
    input  logic B,
    output logic Cout,
    output logic Sum
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks a WIDTH-bit add LSB first.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).
//
// state    | meaning
// ST_IDLE  | waiting for start; operands latched on the accepting edge
// ST_SHIFT | one bit per edge through the fa cell; WIDTH edges total
// ST_DONE  | one-cycle done pulse; sum/cout already hold the new result
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic             carry_q, cout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, last;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] res_next;

    fa u_fa (
        .Cin  (carry_q),
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cout (fa_cout),
        .Sum  (fa_sum)
    );

    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (state_q == ST_SHIFT) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_cout;
            res_q   <= res_next;
            cnt_q   <= cnt_q + CNT_W'(1);
            // Final edge publishes the result including the bit produced this cycle.
            if (last) begin
                sum_q  <= res_next;
                cout_q <= fa_cout;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the last shift edge carry_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_prev;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
    } vec_t;

    vec_t vecs[8];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tcin, input logic [WIDTH-1:0] es, input logic eco,
                          input logic eov, input string nm);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1;
        @(posedge clk); #1;
        chk({nm, " busy_after_accept"}, 32'(busy), 32'd1);
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tcin;
        n = 0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (k == WIDTH / 2) chk({nm, " sum_hold"}, 32'(sum), 32'(exp_prev));
            if (done) begin
                n = k;
                break;
            end
        end
        chk({nm, " done_latency"}, n, WIDTH);
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " cout"}, 32'(cout), 32'(eco));
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, " ovf"}, 32'(ovf), 32'(eov));
`endif
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, " idle_busy"}, 32'(busy), 32'd0);
        exp_prev = es;
    endtask

    initial begin
        int ndone, last_edge, edge_no;
        int pulses[$];

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        exp_prev = '0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
                   $sformatf("vec%0d", i));

        // Start held high through SHIFT/DONE with different operands.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55;
        ndone = 0;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                chk("busyprot sum", 32'(sum), 32'h30);
            end
        end
        chk("busyprot single_done", ndone, 1);
        chk("busyprot idle_reentered", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("busyprot next_accept", 32'(busy), 32'd1);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone = k;
                break;
            end
        end
        chk("busyprot second_latency", ndone, WIDTH);
        chk("busyprot second_sum", 32'(sum), 32'hFF);
        @(posedge clk); #1;
        exp_prev = 8'hFF;

        // Reset mid-operation.
        @(negedge clk);
        a = 8'h81; b = 8'h81; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset sum", 32'(sum), 32'd0);
        chk("midreset cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("midreset no_done", ndone, 0);
        exp_prev = '0;
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_reset");

        // Back-to-back with start held continuously.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        edge_no = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            edge_no++;
            if (done) begin
                pulses.push_back(edge_no);
                chk("b2b sum", 32'(sum), 32'h10);
            end
        end
        start = 1'b0;
        chk("b2b pulse_count", pulses.size(), 3);
        chk("b2b first_latency", (pulses.size() > 0) ? pulses[0] : 0, WIDTH + 1);
        last_edge = (pulses.size() > 0) ? pulses[0] : 0;
        for (int i = 1; i < pulses.size(); i++) begin
            chk("b2b interval", pulses[i] - last_edge, WIDTH + 2);
            last_edge = pulses[i];
        end
        ndone = 0;
        for (int k = 0; k < 3 * WIDTH; k++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ndone = 1;
                break;
            end
        end
        chk("b2b drain", ndone, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
